// File: rtl/serial_to_array.sv
// Packs a valid/ready word stream into OUT_SIZE-lane array beats; SERIAL_TO_ARRAY_ZERO_PAD_EN zeroes unfilled lanes.
// out_valid one cycle after the closing word; in FULL with out_ready low nothing is accepted and the beat holds.
module serial_to_array #(
  parameter int IN_WIDTH = 32,
  parameter int OUT_SIZE = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_WIDTH-1:0]              in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [IN_WIDTH-1:0]              out_data [OUT_SIZE],
  output logic [$clog2(OUT_SIZE+1)-1:0]    out_count,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int CW = $clog2(OUT_SIZE + 1);
  localparam int IW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(OUT_SIZE - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       wr_idx;
  logic [CW-1:0]       count_nxt;
  logic [IN_WIDTH-1:0] data_nxt [OUT_SIZE];
  logic                accept_in;

  assign out_valid = (state == FULL);
  assign in_ready  = rst & ((state == FILL) | ((state == FULL) & out_ready));
  assign accept_in = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      cnt       <= '0;
      out_count <= '0;
      out_data  <= '{default: '0};
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_count <= count_nxt;
      out_data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    count_nxt = out_count;
    data_nxt  = out_data;
    // A word accepted during the output handshake starts the next array at lane 0.
    wr_idx    = (state == FULL) ? '0 : cnt;

    case (state)
      FILL: ;
      FULL: begin
        if (out_ready) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    endcase

    if (accept_in) begin
`ifdef SERIAL_TO_ARRAY_ZERO_PAD_EN
      if (wr_idx == '0) begin
        for (int i = 1; i < OUT_SIZE; i++) begin
          data_nxt[i] = '0;
        end
      end
`endif
      data_nxt[wr_idx] = in_data;
      if ((wr_idx == LAST_LANE) || in_last) begin
        state_nxt = FULL;
        count_nxt = CW'(wr_idx) + CW'(1);
        cnt_nxt   = '0;
      end else begin
        cnt_nxt   = wr_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_to_array.sv
// Directed vector bench for serial_to_array: a 4-lane and a 1-lane instance, 8-bit words.
module tb_serial_to_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] in4_data;
  logic       in4_valid, in4_last, in4_ready;
  logic [7:0] out4_data [4];
  logic [2:0] out4_count;
  logic       out4_valid, out4_ready;

  logic [7:0] in1_data;
  logic       in1_valid, in1_last, in1_ready;
  logic [7:0] out1_data [1];
  logic [0:0] out1_count;
  logic       out1_valid, out1_ready;

  serial_to_array #(.IN_WIDTH(8), .OUT_SIZE(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_data(in4_data), .in_valid(in4_valid), .in_last(in4_last), .in_ready(in4_ready),
    .out_data(out4_data), .out_count(out4_count), .out_valid(out4_valid), .out_ready(out4_ready)
  );

  serial_to_array #(.IN_WIDTH(8), .OUT_SIZE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_data(in1_data), .in_valid(in1_valid), .in_last(in1_last), .in_ready(in1_ready),
    .out_data(out1_data), .out_count(out1_count), .out_valid(out1_valid), .out_ready(out1_ready)
  );

`ifdef SERIAL_TO_ARRAY_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        last;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_lanes;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic vld, input logic [7:0] dat, input logic last,
                              input logic ordy, input logic ir, input logic ov,
                              input logic [2:0] cnt, input logic [31:0] lanes);
    vec_t v;
    v.vld = vld; v.dat = dat; v.last = last; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_cnt = cnt; v.exp_lanes = lanes;
    return v;
  endfunction

  function automatic logic [31:0] lanes4();
    return {out4_data[3], out4_data[2], out4_data[1], out4_data[0]};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    in4_valid  = v.vld;
    in4_data   = v.dat;
    in4_last   = v.last;
    out4_ready = v.ordy;
    #1;
    chk("in_ready", idx, 32'(in4_ready), 32'(v.exp_ir));
    chk("out_valid", idx, 32'(out4_valid), 32'(v.exp_ov));
    if (v.exp_ov) begin
      chk("out_count", idx, 32'(out4_count), 32'(v.exp_cnt));
      chk("out_data", idx, lanes4(), v.exp_lanes);
    end
  endtask

  task automatic step1(input logic vld, input logic [7:0] dat, input logic ov,
                       input logic [7:0] lane, input int idx);
    @(negedge clk);
    in1_valid  = vld;
    in1_data   = dat;
    in1_last   = 1'b0;
    out1_ready = 1'b1;
    #1;
    chk("size1_in_ready", idx, 32'(in1_ready), 32'd1);
    chk("size1_out_valid", idx, 32'(out1_valid), 32'(ov));
    if (ov) begin
      chk("size1_out_count", idx, 32'(out1_count), 32'd1);
      chk("size1_lane0", idx, 32'(out1_data[0]), 32'(lane));
    end
  endtask

  initial begin
    vec_t idle_chk;

    // consecutive 0x10..0x13, then continuous 0x00..0x0B
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 8'(8'h10 + i), 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 1, 1, 1, 4, 32'h13121110));
    for (int i = 1; i < 4; i++) vecs.push_back(mk(1, 8'(i), 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h04, 0, 1, 1, 1, 4, 32'h03020100));
    for (int i = 5; i < 8; i++) vecs.push_back(mk(1, 8'(i), 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h08, 0, 1, 1, 1, 4, 32'h07060504));
    for (int i = 9; i < 12; i++) vecs.push_back(mk(1, 8'(i), 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 4, 32'h0B0A0908));
    // full 0xFF array, then early close after two words
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 8'hFF, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA0, 0, 1, 1, 1, 4, 32'hFFFFFFFF));
    vecs.push_back(mk(1, 8'hA1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 2, PAD ? 32'h0000A1A0 : 32'hFFFFA1A0));
    // backpressure: fill with out_ready low, hold 5 cycles, release with 0x55
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 8'(8'h30 + i), 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 8'h99, 0, 0, 0, 1, 4, 32'h33323130));
    vecs.push_back(mk(1, 8'h55, 0, 1, 1, 1, 4, 32'h33323130));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 8'(8'h56 + i), 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 4, 32'h58575655));
    // in_last on the final lane closes once; in_last on the first lane gives count 1
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 8'(8'h40 + i), 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h43, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 4, 32'h43424140));
    vecs.push_back(mk(1, 8'h77, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 1, PAD ? 32'h00000077 : 32'h43424177));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0));

    rst = 1'b0;
    in4_valid = 0; in4_data = 0; in4_last = 0; out4_ready = 0;
    in1_valid = 0; in1_data = 0; in1_last = 0; out1_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 0, 32'(in4_ready), 32'd0);
    chk("rst_out_valid", 0, 32'(out4_valid), 32'd0);
    chk("rst_out_count", 0, 32'(out4_count), 32'd0);
    chk("rst_out_data", 0, lanes4(), 32'd0);
    chk("rst_size1_in_ready", 0, 32'(in1_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 0, 32'(in4_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // async reset mid-fill
    apply(mk(1, 8'hE0, 0, 1, 1, 0, 0, 0), 100);
    apply(mk(1, 8'hE1, 0, 1, 1, 0, 0, 0), 101);
    @(posedge clk);
    #2;
    rst = 1'b0;
    in4_valid = 1'b0;
    #1;
    chk("midfill_rst_in_ready", 102, 32'(in4_ready), 32'd0);
    chk("midfill_rst_out_valid", 102, 32'(out4_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // async reset while a beat is pending
    for (int i = 0; i < 4; i++) apply(mk(1, 8'(8'hC0 + i), 0, 0, 1, 0, 0, 0), 110 + i);
    apply(mk(0, 8'h00, 0, 0, 0, 1, 4, 32'hC3C2C1C0), 114);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midfull_rst_out_valid", 115, 32'(out4_valid), 32'd0);
    chk("midfull_rst_in_ready", 115, 32'(in4_ready), 32'd0);
    chk("midfull_rst_out_count", 115, 32'(out4_count), 32'd0);
    chk("midfull_rst_out_data", 115, lanes4(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) apply(mk(1, 8'(8'h20 + i), 0, 1, 1, 0, 0, 0), 120 + i);
    apply(mk(0, 8'h00, 0, 1, 1, 1, 4, 32'h23222120), 124);
    idle_chk = mk(0, 8'h00, 0, 1, 1, 0, 0, 0);
    apply(idle_chk, 125);

    // single-lane instance: one beat per cycle
    step1(1, 8'h01, 0, 8'h00, 200);
    step1(1, 8'h02, 1, 8'h01, 201);
    step1(1, 8'h03, 1, 8'h02, 202);
    step1(0, 8'h00, 1, 8'h03, 203);
    step1(0, 8'h00, 0, 8'h00, 204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
